kds_loader: RTL and testbench
=============================

// Module: kds_loader
// PURPOSE
// Sequencer and writer for the KDS kernel data shifter: the other end of its load/cycle interface.
// - Accepts a valid/ready stream of kernel words from external memory.
// - Packs each group of three words onto v_1/v_2/v_3.
// - Pulses one-hot LE_select to push each triple into its block, until every block FIFO holds FIFO_DEPTH entries.
// - Afterwards, drives cycle_enable/only_readout to rotate (recirculate) or drain the shifter.
// PARAMETERS
// IO_DATA_WIDTH  16  width of kernel words and v_1..v_3
// NB_BLOCKS      12  number of KDS blocks (width of LE_select)
// FIFO_DEPTH     8   entries per KDS block FIFO (2**LOG2_OF_DEPTH)
// PORTS
// clk           in   1              clock, all state updates on rising edge
// arst_n_in     in   1              asynchronous reset, active low
// start         in   1              pulse: begin a new load (honoured in IDLE only)
// in_data       in   IO_DATA_WIDTH  kernel word stream
// in_valid      in   1              in_data valid
// in_ready      out  1              loader accepts in_data this cycle
// cycle_req     in   1              pulse: rotate shifter one step (LOADED only)
// drain_req     in   1              pulse: read out and empty shifter (LOADED only)
// v_1,v_2,v_3   out  IO_DATA_WIDTH  triple presented to KDS
// LE_select     out  NB_BLOCKS      one-hot block write enable to KDS
// cycle_enable  out  1              KDS FIFO pop / recirculate
// only_readout  out  1              KDS write-back inhibit during drain
// load_done     out  1              high while in LOADED
// busy          out  1              high in any state except IDLE
// BEHAVIOUR
// - Reset (async, any time, including mid-load or mid-drain):
//   - State -> IDLE; all counters 0.
//   - Every output 0 (in_ready, v_*, LE_select, cycle_enable, only_readout, load_done, busy).
//   - KDS shares arst_n_in, so its contents are cleared at the same time.
// - States: IDLE, LOAD, ISSUE, LOADED, DRAIN.
// - Counters: word_cnt (0..2), blk_cnt (0..NB_BLOCKS-1), ent_cnt (0..FIFO_DEPTH-1), drn_cnt (0..FIFO_DEPTH-1).
// - IDLE: in_ready=0. start=1 -> LOAD; word_cnt, blk_cnt and ent_cnt cleared.
// - LOAD:
//   - in_ready=1. A word transfers when in_valid && in_ready.
//   - Word 0/1/2 is registered into v_1/v_2/v_3 respectively; word_cnt++.
//   - The transfer of word 2 -> ISSUE next cycle.
// - ISSUE (exactly one cycle):
//   - LE_select = 1<<blk_cnt; in_ready=0; v_* held stable; cycle_enable=0; only_readout=0.
//   - The next word is therefore never presented while LE_select is high.
//   - Sustained throughput is 3 words per 4 cycles.
//   - Leaving ISSUE: word_cnt=0. blk_cnt++.
//   - When blk_cnt wraps from NB_BLOCKS-1 to 0, ent_cnt++.
//   - Order is entry-major: all blocks receive entry 0, then entry 1, and so on.
//   - Last triple (blk_cnt=NB_BLOCKS-1 and ent_cnt=FIFO_DEPTH-1) -> LOADED; otherwise -> LOAD.
//   - A FIFO is never written beyond FIFO_DEPTH.
// - LOADED: load_done=1; in_ready=0; in_valid ignored.
//   - cycle_req -> cycle_enable=1 for exactly the next cycle, only_readout=0.
//     - This rotates every block one step; the state stays LOADED.
//     - Back-to-back cycle_req gives a continuous cycle_enable.
//   - drain_req -> DRAIN; drn_cnt cleared.
//   - drain_req and cycle_req in the same cycle: drain wins, the cycle request is dropped.
// - DRAIN:
//   - cycle_enable=1 and only_readout=1 for exactly FIFO_DEPTH consecutive cycles; LE_select=0.
//   - After the last drain cycle -> IDLE; busy=0 on the following cycle.
// - start outside IDLE is ignored; cycle_req/drain_req outside LOADED are ignored.
// - Invariants:
//   - LE_select is 0 or one-hot, and is never non-zero together with cycle_enable.
//   - only_readout=1 implies cycle_enable=1.
// - No arithmetic on the data path; v_* are registered copies of in_data, full width, unmodified.
// TESTING
// - Reset then idle: all outputs 0; in_valid=1 with no start -> in_ready stays 0 and LE_select stays 0.
// - Full load, in_valid always 1, data = 0,1,2,...:
//   - 288 words accepted.
//   - 1st ISSUE: LE_select=12'h001, v=(0,1,2). 12th ISSUE: LE_select=12'h800, v=(33,34,35).
//   - load_done rises after the 96th ISSUE; in_ready low in every ISSUE cycle.
// - Random in_valid gaps during load: identical LE_select/v_* sequence; v_* stable for the whole LE_select cycle.
// - LOADED, 3 single-cycle cycle_req pulses -> 3 single cycle_enable pulses, only_readout=0, state remains LOADED.
// - drain_req together with cycle_req -> cycle_enable=1 and only_readout=1 for exactly 8 cycles, then busy=0.
//   - The KDS model outputs the 8 loaded entries per block in load order.
// - arst_n_in low after 100 accepted words: outputs 0 at once; a new start reloads from blk_cnt=0, ent_cnt=0.

Source files
------------

// File: rtl/kds_loader.sv
// Loader/sequencer for the KDS kernel data shifter.
// It packs streamed kernel words into triples and writes them into the blocks entry-major, then rotates or drains them.
module kds_loader #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int NB_BLOCKS     = 12,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     start,
    input  logic [IO_DATA_WIDTH-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     cycle_req,
    input  logic                     drain_req,
    output logic [IO_DATA_WIDTH-1:0] v_1,
    output logic [IO_DATA_WIDTH-1:0] v_2,
    output logic [IO_DATA_WIDTH-1:0] v_3,
    output logic [NB_BLOCKS-1:0]     LE_select,
    output logic                     cycle_enable,
    output logic                     only_readout,
    output logic                     load_done,
    output logic                     busy
);

    localparam int BLK_W = (NB_BLOCKS > 1) ? $clog2(NB_BLOCKS) : 1;
    localparam int ENT_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NB_BLOCKS - 1);
    localparam logic [ENT_W-1:0] ENT_LAST = ENT_W'(FIFO_DEPTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_LOADED = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]               state_reg;
    logic [2:0]               state_next;
    logic [1:0]               word_cnt_reg;
    logic [BLK_W-1:0]         blk_cnt_reg;
    logic [ENT_W-1:0]         ent_cnt_reg;
    logic [ENT_W-1:0]         drn_cnt_reg;
    logic [IO_DATA_WIDTH-1:0] v_1_reg;
    logic [IO_DATA_WIDTH-1:0] v_2_reg;
    logic [IO_DATA_WIDTH-1:0] v_3_reg;
    logic                     cyc_pulse_reg;

    logic word_xfer;
    logic last_triple;

    assign word_xfer   = (state_reg == S_LOAD) && in_valid;
    assign last_triple = (blk_cnt_reg == BLK_LAST) && (ent_cnt_reg == ENT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   if (word_xfer && (word_cnt_reg == 2'd2)) state_next = S_ISSUE;
            S_ISSUE:  state_next = last_triple ? S_LOADED : S_LOAD;
            S_LOADED: if (drain_req) state_next = S_DRAIN;
            S_DRAIN:  if (drn_cnt_reg == ENT_LAST) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_reg     <= S_IDLE;
            word_cnt_reg  <= '0;
            blk_cnt_reg   <= '0;
            ent_cnt_reg   <= '0;
            drn_cnt_reg   <= '0;
            v_1_reg       <= '0;
            v_2_reg       <= '0;
            v_3_reg       <= '0;
            cyc_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            // A drain request in the same cycle as a rotate request swallows the rotate.
            cyc_pulse_reg <= (state_reg == S_LOADED) && cycle_req && !drain_req;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        word_cnt_reg <= '0;
                        blk_cnt_reg  <= '0;
                        ent_cnt_reg  <= '0;
                    end
                end
                S_LOAD: begin
                    if (word_xfer) begin
                        word_cnt_reg <= word_cnt_reg + 2'd1;
                        case (word_cnt_reg)
                            2'd0:    v_1_reg <= in_data;
                            2'd1:    v_2_reg <= in_data;
                            default: v_3_reg <= in_data;
                        endcase
                    end
                end
                S_ISSUE: begin
                    word_cnt_reg <= '0;
                    if (blk_cnt_reg == BLK_LAST) begin
                        blk_cnt_reg <= '0;
                        ent_cnt_reg <= (ent_cnt_reg == ENT_LAST) ? '0 : ent_cnt_reg + ENT_W'(1);
                    end else begin
                        blk_cnt_reg <= blk_cnt_reg + BLK_W'(1);
                    end
                end
                S_LOADED: begin
                    if (drain_req) drn_cnt_reg <= '0;
                end
                S_DRAIN: begin
                    drn_cnt_reg <= drn_cnt_reg + ENT_W'(1);
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB_BLOCKS; gi++) begin : g_le
            assign LE_select[gi] = (state_reg == S_ISSUE) && (blk_cnt_reg == BLK_W'(gi));
        end
    endgenerate

    assign in_ready     = (state_reg == S_LOAD);
    assign v_1          = v_1_reg;
    assign v_2          = v_2_reg;
    assign v_3          = v_3_reg;
    assign cycle_enable = cyc_pulse_reg || (state_reg == S_DRAIN);
    assign only_readout = (state_reg == S_DRAIN);
    assign load_done    = (state_reg == S_LOADED);
    assign busy         = (state_reg != S_IDLE);

    a_le_onehot: assert property (@(posedge clk) disable iff (!arst_n_in)
        $onehot0(LE_select) && !((|LE_select) && cycle_enable));

endmodule

// File: tb/tb_kds_loader.sv
// Randomised bench for kds_loader with a queue-level model of the loaded KDS blocks.
module tb_kds_loader;

    localparam int W      = 16;
    localparam int NB     = 12;
    localparam int D      = 8;
    localparam int NISS   = NB * D;
    localparam int NWORDS = 3 * NISS;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          start;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          cycle_req;
    logic          drain_req;
    logic [W-1:0]  v_1, v_2, v_3;
    logic [NB-1:0] LE_select;
    logic          cycle_enable;
    logic          only_readout;
    logic          load_done;
    logic          busy;

    kds_loader #(.IO_DATA_WIDTH(W), .NB_BLOCKS(NB), .FIFO_DEPTH(D)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .cycle_req(cycle_req),
        .drain_req(drain_req), .v_1(v_1), .v_2(v_2), .v_3(v_3),
        .LE_select(LE_select), .cycle_enable(cycle_enable),
        .only_readout(only_readout), .load_done(load_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0]   words [NWORDS];
    int             sent_idx, acc_n, cyc, inv_err, ce_n, ro_n, start_cyc, ld_cyc;
    logic [NB-1:0]  iss_le_q [$];
    logic [3*W-1:0] iss_v_q  [$];
    int             iss_cyc_q[$];
    logic [3*W-1:0] kds_fifo [NB][D+1];
    int             kds_cnt  [NB];
    logic [3*W-1:0] drain_out[NB][D];
    int             drain_cnt[NB];

    task automatic clear_model();
        iss_le_q.delete(); iss_v_q.delete(); iss_cyc_q.delete();
        acc_n = 0; sent_idx = 0; inv_err = 0; ce_n = 0; ro_n = 0;
        for (int b = 0; b < NB; b++) begin
            kds_cnt[b] = 0;
            drain_cnt[b] = 0;
        end
    endtask

    // Observe one cycle (inputs already applied), update the block model, then advance a clock.
    task automatic step();
        logic [3*W-1:0] head;
        if (in_valid && in_ready) begin
            acc_n++;
            if (sent_idx < NWORDS) sent_idx++;
        end
        if (LE_select != '0) begin
            iss_le_q.push_back(LE_select);
            iss_v_q.push_back({v_1, v_2, v_3});
            iss_cyc_q.push_back(cyc);
            if ($countones(LE_select) != 1 || in_ready || cycle_enable) inv_err++;
            for (int b = 0; b < NB; b++)
                if (LE_select[b] && kds_cnt[b] < D + 1) begin
                    kds_fifo[b][kds_cnt[b]] = {v_1, v_2, v_3};
                    kds_cnt[b]++;
                end
        end
        if (only_readout && !cycle_enable) inv_err++;
        if (cycle_enable) begin
            ce_n++;
            if (only_readout) ro_n++;
            for (int b = 0; b < NB; b++)
                if (kds_cnt[b] > 0) begin
                    head = kds_fifo[b][0];
                    for (int k = 0; k < D; k++) kds_fifo[b][k] = kds_fifo[b][k+1];
                    kds_cnt[b]--;
                    if (only_readout) begin
                        if (drain_cnt[b] < D) drain_out[b][drain_cnt[b]] = head;
                        drain_cnt[b]++;
                    end else begin
                        kds_fifo[b][kds_cnt[b]] = head;
                        kds_cnt[b]++;
                    end
                end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Stimulus only: start a load and stream words until LOADED, budget expiry or abort point.
    task automatic drive_load(input bit gaps, input bit seq, input int abort_after);
        for (int i = 0; i < NWORDS; i++) words[i] = seq ? W'(i) : W'($urandom);
        clear_model();
        start_cyc = cyc;
        start = 1'b1; in_valid = 1'b0; in_data = words[0];
        step();
        start = 1'b0;
        for (int k = 0; k < 3000 && !load_done; k++) begin
            if (abort_after > 0 && acc_n >= abort_after) break;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = (sent_idx < NWORDS) ? words[sent_idx] : W'($urandom);
            step();
        end
        ld_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        arst_n_in = 1'b0; start = 0; in_valid = 0; in_data = '0; cycle_req = 0; drain_req = 0;
        cyc = 0;
        clear_model();
        #2;
        n_cmp++;
        if ({in_ready, LE_select, v_1, v_2, v_3, cycle_enable, only_readout, load_done, busy} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got in_ready=%b LE=%h busy=%b load_done=%b ce=%b, want all 0",
                in_ready, LE_select, busy, load_done, cycle_enable);
        end
        @(posedge clk); #1;
        arst_n_in = 1'b1;
        step();
        n_cmp++;
        if ({in_ready, LE_select, v_1, v_2, v_3, cycle_enable, only_readout, load_done, busy} !== '0) begin
            n_err++; $display("FAIL idle_outputs: got in_ready=%b LE=%h busy=%b, want all 0", in_ready, LE_select, busy);
        end
        in_valid = 1'b1; in_data = 16'h1234;
        for (int k = 0; k < 10; k++) begin
            cycle_req = (k == 2); drain_req = (k == 5);
            step();
        end
        in_valid = 0; cycle_req = 0; drain_req = 0;
        n_cmp++;
        if (acc_n !== 0 || iss_le_q.size() !== 0) begin
            n_err++; $display("FAIL idle_no_accept: accepted=%0d issues=%0d, want 0/0", acc_n, iss_le_q.size());
        end
        n_cmp++;
        if (ce_n !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL idle_ignore_req: cycle_enable cycles=%0d busy=%b, want 0/0", ce_n, busy);
        end
    endtask

    task automatic test_full_load(input bit gaps, input bit seq);
        int n;
        drive_load(gaps, seq, 0);
        n_cmp++;
        if (load_done !== 1'b1) begin
            n_err++; $display("FAIL load_timeout: load_done=%b after budget, want 1", load_done);
        end
        n_cmp++;
        if (acc_n !== NWORDS || iss_le_q.size() !== NISS) begin
            n_err++; $display("FAIL load_counts: accepted=%0d issues=%0d, want %0d/%0d", acc_n, iss_le_q.size(), NWORDS, NISS);
        end
        for (n = 0; n < NISS && n < iss_le_q.size(); n++) begin
            n_cmp++;
            if (iss_le_q[n] !== NB'(1) << (n % NB) ||
                iss_v_q[n] !== {words[3*n], words[3*n+1], words[3*n+2]}) begin
                n_err++; $display("FAIL issue_%0d: LE=%h v=%h, want LE=%h v=%h", n, iss_le_q[n], iss_v_q[n],
                    NB'(1) << (n % NB), {words[3*n], words[3*n+1], words[3*n+2]});
            end
        end
        if (seq && iss_le_q.size() >= NB) begin
            n_cmp++;
            if (iss_le_q[0] !== 12'h001 || iss_v_q[0] !== {16'd0, 16'd1, 16'd2}) begin
                n_err++; $display("FAIL first_issue: LE=%h v=%h, want 001 / 0,1,2", iss_le_q[0], iss_v_q[0]);
            end
            n_cmp++;
            if (iss_le_q[NB-1] !== 12'h800 || iss_v_q[NB-1] !== {16'd33, 16'd34, 16'd35}) begin
                n_err++; $display("FAIL twelfth_issue: LE=%h v=%h, want 800 / 33,34,35", iss_le_q[NB-1], iss_v_q[NB-1]);
            end
        end
        if (iss_cyc_q.size() == NISS) begin
            n_cmp++;
            if (ld_cyc !== iss_cyc_q[NISS-1] + 1) begin
                n_err++; $display("FAIL load_done_rise: at cycle %0d, want %0d", ld_cyc, iss_cyc_q[NISS-1] + 1);
            end
        end
        if (!gaps) begin
            n_cmp++;
            if (ld_cyc - start_cyc !== 1 + 4 * NISS) begin
                n_err++; $display("FAIL load_throughput: %0d cycles, want %0d", ld_cyc - start_cyc, 1 + 4 * NISS);
            end
        end
        n_cmp++;
        if (inv_err !== 0) begin
            n_err++; $display("FAIL load_invariants: %0d violations, want 0", inv_err);
        end
    endtask

    task automatic test_cycle();
        int acc0, ce0, ro0;
        acc0 = acc_n; ce0 = ce_n; ro0 = ro_n;
        in_valid = 1'b1; in_data = W'($urandom);
        for (int p = 0; p < 3; p++) begin
            cycle_req = 1'b1; step(); cycle_req = 1'b0;
            n_cmp++;
            if (cycle_enable !== 1'b1 || only_readout !== 1'b0) begin
                n_err++; $display("FAIL cycle_pulse_%0d: ce=%b ro=%b, want 1/0", p, cycle_enable, only_readout);
            end
            step();
            n_cmp++;
            if (cycle_enable !== 1'b0 || load_done !== 1'b1) begin
                n_err++; $display("FAIL cycle_single_%0d: ce=%b load_done=%b, want 0/1", p, cycle_enable, load_done);
            end
            repeat ($urandom_range(0, 2)) step();
        end
        start = 1'b1; step(); start = 1'b0;
        cycle_req = 1'b1;
        repeat (5) step();
        cycle_req = 1'b0;
        repeat (3) step();
        in_valid = 1'b0;
        n_cmp++;
        if (ce_n - ce0 !== 8 || ro_n !== ro0) begin
            n_err++; $display("FAIL cycle_count: ce cycles=%0d ro cycles=%0d, want 8/0", ce_n - ce0, ro_n - ro0);
        end
        n_cmp++;
        if (load_done !== 1'b1 || busy !== 1'b1 || acc_n !== acc0) begin
            n_err++; $display("FAIL cycle_stays_loaded: load_done=%b busy=%b accepted=%0d, want 1/1/%0d",
                load_done, busy, acc_n, acc0);
        end
    endtask

    task automatic test_drain(input int rot);
        logic ce_s[10], ro_s[10], bz_s[10];
        int ce0, bad, e, n;
        ce0 = ce_n;
        drain_req = 1'b1; cycle_req = 1'b1; step();
        drain_req = 1'b0; cycle_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ce_s[k] = cycle_enable; ro_s[k] = only_readout; bz_s[k] = busy;
            step();
        end
        bad = 0;
        for (int k = 0; k < D; k++) if (!(ce_s[k] && ro_s[k] && bz_s[k])) bad++;
        n_cmp++;
        if (bad !== 0 || ce_n - ce0 !== D) begin
            n_err++; $display("FAIL drain_window: %0d bad cycles, ce cycles=%0d, want 0/%0d", bad, ce_n - ce0, D);
        end
        n_cmp++;
        if (ce_s[D] !== 1'b0 || ro_s[D] !== 1'b0 || bz_s[D] !== 1'b0) begin
            n_err++; $display("FAIL drain_end: ce=%b ro=%b busy=%b, want 0/0/0", ce_s[D], ro_s[D], bz_s[D]);
        end
        for (int b = 0; b < NB; b++) begin
            bad = 0;
            for (int k = 0; k < D; k++) begin
                e = (k + rot) % D;
                n = e * NB + b;
                if (drain_out[b][k] !== {words[3*n], words[3*n+1], words[3*n+2]}) bad++;
            end
            n_cmp++;
            if (bad !== 0 || drain_cnt[b] !== D) begin
                n_err++; $display("FAIL drain_block_%0d: %0d wrong entries, %0d drained, want 0/%0d", b, bad, drain_cnt[b], D);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic was_busy;
        drive_load(1'b1, 1'b0, 100);
        was_busy = busy;
        arst_n_in = 1'b0;
        #1;
        n_cmp++;
        if (was_busy !== 1'b1 || acc_n !== 100) begin
            n_err++; $display("FAIL abort_point: busy=%b accepted=%0d, want 1/100", was_busy, acc_n);
        end
        n_cmp++;
        if ({in_ready, LE_select, v_1, v_2, v_3, cycle_enable, only_readout, load_done, busy} !== '0) begin
            n_err++; $display("FAIL async_reset: in_ready=%b LE=%h v_1=%h busy=%b, want all 0", in_ready, LE_select, v_1, busy);
        end
        @(posedge clk); @(posedge clk); #1;
        arst_n_in = 1'b1;
        clear_model();
        step();
        test_full_load(1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_load(1'b0, 1'b1);
        test_cycle();
        test_drain(8);
        test_full_load(1'b1, 1'b1);
        test_drain(0);
        test_reset_mid_load();
        test_drain(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
